// File: rtl/sine_pkg.sv
// Shared widths, midscale constant and quadrant encoding for the DDS sine front end.
package sine_pkg;

    localparam int unsigned DEF_PHASE_W = 16;
    localparam int unsigned DEF_ADDR_W  = 6;
    localparam int unsigned DEF_DATA_W  = 12;
    localparam int unsigned MIDSCALE    = 1 << (DEF_DATA_W - 1);

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

endpackage

// File: rtl/quadrant_mapper.sv
// Quarter-wave symmetry: SAMPLE_MODE=0 mirrors the table index in quadrants 1/3,
// SAMPLE_MODE=1 turns a ROM magnitude into an offset-binary sample (negated in quadrants 2/3).
module quadrant_mapper
    import sine_pkg::*;
#(
    parameter bit          SAMPLE_MODE = 1'b0,
    parameter int unsigned IN_W        = DEF_ADDR_W,
    parameter int unsigned OUT_W       = DEF_ADDR_W
) (
    input  quad_t             i_quad,
    input  logic [IN_W-1:0]   i_val,
    output logic [OUT_W-1:0]  o_val
);

    generate
        if (SAMPLE_MODE) begin : g_sample
            localparam logic [OUT_W:0] MID = (OUT_W + 1)'(1) << (OUT_W - 1);

            logic [OUT_W:0] w_mag_ext;
            logic           w_unused_carry;

            assign w_mag_ext = (OUT_W + 1)'(i_val);

            // Magnitude never exceeds MID-1, so the carry/borrow bit is always zero.
            always_comb begin
                {w_unused_carry, o_val} = MID + w_mag_ext;
                case (i_quad)
                    Q0, Q1:  {w_unused_carry, o_val} = MID + w_mag_ext;
                    Q2, Q3:  {w_unused_carry, o_val} = MID - w_mag_ext;
                    default: {w_unused_carry, o_val} = MID + w_mag_ext;
                endcase
            end
        end else begin : g_addr
            always_comb begin
                o_val = OUT_W'(i_val);
                case (i_quad)
                    Q1, Q3:  o_val = OUT_W'(~i_val);
                    default: o_val = OUT_W'(i_val);
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/sine_phase_gen.sv
// DDS front end: phase accumulator -> quarter-wave ROM address -> symmetric offset-binary
// sample with a one-cycle valid, three edges from en to d_valid.
module sine_phase_gen
    import sine_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [PHASE_W-1:0] freq_word,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  d_out,
    output logic               d_valid
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

    logic [PHASE_W-1:0] r_phase;
    quad_t              r_quad_s1;
    quad_t              r_quad_s2;
    logic               r_vld_s1;
    logic               r_vld_s2;

    quad_t              w_quad;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-2:0]  w_mag;
    logic [DATA_W-1:0]  w_sample;
    logic               w_unused_rom_msb;

    assign w_quad           = quad_t'(r_phase[PHASE_W-1 -: 2]);
    assign w_idx            = r_phase[PHASE_W-3 -: ADDR_W];
    assign w_mag            = rom_data[DATA_W-2:0];
    assign w_unused_rom_msb = rom_data[DATA_W-1];

    quadrant_mapper #(
        .SAMPLE_MODE (1'b0),
        .IN_W        (ADDR_W),
        .OUT_W       (ADDR_W)
    ) u_addr_map (
        .i_quad (w_quad),
        .i_val  (w_idx),
        .o_val  (w_addr)
    );

    quadrant_mapper #(
        .SAMPLE_MODE (1'b1),
        .IN_W        (DATA_W - 1),
        .OUT_W       (DATA_W)
    ) u_sample_map (
        .i_quad (r_quad_s2),
        .i_val  (w_mag),
        .o_val  (w_sample)
    );

    // Stage 0 addresses with the current phase, so a clear on the same edge only affects later samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            r_quad_s1 <= Q0;
            r_vld_s1  <= 1'b0;
            r_quad_s2 <= Q0;
            r_vld_s2  <= 1'b0;
            d_out     <= MID;
            d_valid   <= 1'b0;
        end else begin
            rom_en   <= en;
            r_vld_s1 <= en;
            if (en) begin
                rom_addr  <= w_addr;
                r_quad_s1 <= w_quad;
            end

            if (sync_clr) begin
                r_phase <= '0;
            end else if (en) begin
                r_phase <= r_phase + freq_word;
            end

            r_quad_s2 <= r_quad_s1;
            r_vld_s2  <= r_vld_s1;

            d_valid <= r_vld_s2;
            if (r_vld_s2) begin
                d_out <= w_sample;
            end
        end
    end

endmodule
